// File: rtl/registro_d_4bits.sv
// Parallel-load data register with whole-word load enable.
// Asynchronous active-high reset forces Q to RESET_VALUE.
module registro_d_4bits #(
  parameter int unsigned            WIDTH       = 4,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (EN) begin
      q_d = D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // Q comes straight from the flops; no input reaches it combinationally.
  assign Q = q_q;

endmodule

// File: tb/tb_registro_d_4bits.sv
// Directed bench for registro_d_4bits: vector table plus reset corner cases.
// A second instance checks a non-zero RESET_VALUE at a wider WIDTH.
module tb_registro_d_4bits;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] d;
  logic [3:0] q;

  logic [7:0] d8;
  logic [7:0] q8;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       en;
    logic [3:0] d;
    logic [3:0] exp_q;
    string      name;
  } vec_t;

  vec_t vecs[$];

  registro_d_4bits dut (
    .clk(clk),
    .rst(rst),
    .EN (en),
    .D  (d),
    .Q  (q)
  );

  registro_d_4bits #(
    .WIDTH      (8),
    .RESET_VALUE(8'hA5)
  ) dut8 (
    .clk(clk),
    .rst(rst),
    .EN (en),
    .D  (d8),
    .Q  (q8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    en  = 1'b0;
    d   = 4'b0000;
    d8  = 8'h00;

    vecs.push_back('{1'b1, 4'b1010, 4'b1010, "load_1010"});
    vecs.push_back('{1'b0, 4'b0101, 4'b1010, "hold_0101"});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, "load_1111"});
    vecs.push_back('{1'b0, 4'b0000, 4'b1111, "hold_0000"});
    vecs.push_back('{1'b1, 4'b0001, 4'b0001, "b2b_0001"});
    vecs.push_back('{1'b1, 4'b0010, 4'b0010, "b2b_0010"});
    vecs.push_back('{1'b1, 4'b0100, 4'b0100, "b2b_0100"});
    vecs.push_back('{1'b1, 4'b1000, 4'b1000, "b2b_1000"});
    vecs.push_back('{1'b0, 4'b0011, 4'b1000, "hold_0011"});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, "load_pre_rst"});

    // Reset before any clock edge (first rising edge is at 5 ns).
    #1 rst = 1'b1;
    #1;
    check("rst_no_edge", {4'b0, q}, 8'h00);
    check("rst_no_edge_w8", q8, 8'hA5);

    // Reset held across two enabled edges.
    en = 1'b1;
    d  = 4'b1111;
    d8 = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_held", {4'b0, q}, 8'h00);
    check("rst_held_w8", q8, 8'hA5);

    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      en = vecs[i].en;
      d  = vecs[i].d;
      #1;
      check({vecs[i].name, "_pre_edge"}, {4'b0, q},
            {4'b0, (i == 0) ? 4'b0000 : vecs[i-1].exp_q});
      @(posedge clk);
      #1;
      check(vecs[i].name, {4'b0, q}, {4'b0, vecs[i].exp_q});
    end

    // Async reset between edges while holding 1111.
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_mid", {4'b0, q}, 8'h00);
    en = 1'b1;
    d  = 4'b0110;
    @(posedge clk);
    #1;
    check("rst_blocks_load", {4'b0, q}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("load_after_rst", {4'b0, q}, 8'h06);

    // Wide instance loads and holds too.
    @(negedge clk);
    d8 = 8'h3C;
    @(posedge clk);
    #1;
    check("load_w8", q8, 8'h3C);
    @(negedge clk);
    en = 1'b0;
    d8 = 8'hC3;
    @(posedge clk);
    #1;
    check("hold_w8", q8, 8'h3C);

    // Reset rising on the same edge as an enabled load: reset wins.
    @(negedge clk);
    en = 1'b1;
    d  = 4'b1001;
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("rst_same_edge", {4'b0, q}, 8'h00);
    check("rst_same_edge_w8", q8, 8'hA5);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("load_1001", {4'b0, q}, 8'h09);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
